reg_mem_bist: RTL and testbench
===============================

Name: reg_mem_bist

Overview:
- Hardware initiator for a `reg_mem` instance: drives `addr`/`data_in`/`wen` and checks `data_out`.
- Sweeps every address twice:
  - Pass A: writes then reads back a true pattern.
  - Pass B: writes then reads back the inverted pattern.
- Counts every mismatch and reports pass/fail.
- Sits between the system controller and the register memory; used for power-on self-test.

Parameters:
- DATA_WIDTH, 8, width of the memory word.
- ADDR_BITS, 5, memory address width; depth = 2**ADDR_BITS.
- RD_LAT, 1, cycles from address presented to valid `mem_dout`; legal values 0, 1, 2.
- PATTERN_SEED, 8'hA5, XORed into the pattern; truncated or zero-extended to DATA_WIDTH.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  request to run the BIST; sampled only in IDLE.
- mem_addr  out  ADDR_BITS  address to `reg_mem`.
- mem_din  out  DATA_WIDTH  write data to `reg_mem`.
- mem_wen  out  1  write enable to `reg_mem`.
- mem_dout  in  DATA_WIDTH  read data from `reg_mem`.
- busy  out  1  high while the test runs.
- done  out  1  one-cycle pulse when the test completes.
- pass  out  1  high when the last run had zero mismatches; valid from `done`.
- err_count  out  ADDR_BITS+2  mismatch count of the last run; saturates at all-ones.
- fail_addr  out  ADDR_BITS  present only with the optional feature.
- fail_data  out  DATA_WIDTH  present only with the optional feature.

Behaviour:
- Reset (async, immediate):
  - state = IDLE.
  - mem_addr = 0, mem_din = 0, mem_wen = 0.
  - busy = 0, done = 0, pass = 0, err_count = 0.
  - Read pipeline cleared.
- Reset asserted mid-run aborts the run; no `done` is produced.
- Pattern:
  - P(a) = {zero-extended/truncated a} XOR PATTERN_SEED.
  - Pass A data = P(a); pass B data = ~P(a).
- State machine: IDLE -> WR_A -> RD_A -> WR_B -> RD_B -> FIN -> IDLE.
- IDLE:
  - `start` = 1 at a clock edge clears err_count and pass, sets busy, goes to WR_A with addr = 0.
  - `start` in any other state is ignored.
- WR_x:
  - mem_wen = 1 with mem_addr = a and mem_din = pattern each cycle, a = 0 .. 2**ADDR_BITS-1.
  - After the last address, go to RD_x with addr = 0 and mem_wen = 0.
- RD_x:
  - Issue one address per cycle, mem_wen = 0.
  - Expected data and a valid bit travel through an RD_LAT-deep delay line.
  - Compare when the delayed valid bit is high.
  - After the last address is issued, stay RD_LAT more cycles to drain.
  - Then go to the next state.
- Compare rule: mismatch when mem_dout != delayed expected; err_count increments by 1, saturating.
- FIN (one cycle):
  - done = 1, busy = 0.
  - pass = (err_count == 0), including the result of the final compare.
- Timing:
  - Each WR phase takes 2**ADDR_BITS cycles.
  - Each RD phase takes 2**ADDR_BITS + RD_LAT cycles.
  - Defaults: `done` asserts 130 cycles after the start-accepting edge.
- Outputs `pass` and `err_count` hold until the next accepted `start`.
- Address counter wraps from all-ones to 0 on the phase transition only; no extra cycle.
- `mem_addr`, `mem_din`, `mem_wen` are registered outputs.

Optional Feature:
- Macro: REG_MEM_BIST_FAILLOG_EN.
- Defined:
  - `fail_addr`/`fail_data` capture the address and the read data of the first mismatch of a run.
  - They are cleared to 0 on reset and on an accepted `start`.
  - Later mismatches do not overwrite them.
- Undefined: the ports and capture registers do not exist; all other behaviour is identical.

Test Plan:
- Clean memory model, defaults, `start` pulse:
  - `busy` rises the next cycle.
  - `done` pulses exactly 130 cycles after the accepting edge.
  - pass = 1, err_count = 0.
- Write trace check: log (mem_addr, mem_din) while mem_wen = 1.
  - Pass A: address 0 gets 8'hA5, address 31 gets 8'hBA.
  - Pass B: address 0 gets 8'h5A.
  - Exactly 64 write cycles.
- Memory model with bit 0 of address 7 stuck at 1:
  - Pass A expected at address 7 is 8'hA2, so it fails; pass B expected is 8'h5D, bit 0 already 1, so it does not fail.
  - err_count = 1, pass = 0.
  - With REG_MEM_BIST_FAILLOG_EN: fail_addr = 7, fail_data = 8'hA3.
- Model data_out as all-zeros:
  - Every compare fails (P never equals both 0 and ~0).
  - err_count = 64, pass = 0.
- Assert `rst` 40 cycles into the run:
  - All outputs return to reset values immediately.
  - No `done` pulse.
  - A new `start` then completes with pass = 1.
- RD_LAT = 0 and RD_LAT = 2 with matching memory models:
  - `done` at 128 and 132 cycles respectively.
  - pass = 1 in both.
  - `start` pulsed while busy is ignored.

Source files
------------

// File: rtl/reg_mem_bist.sv
// rtl/reg_mem_bist.sv - march-style write/readback self-test initiator for a reg_mem instance.
// Optional first-failure log enabled by defining REG_MEM_BIST_FAILLOG_EN.
module reg_mem_bist #(
  parameter int          DATA_WIDTH   = 8,
  parameter int          ADDR_BITS    = 5,
  parameter int          RD_LAT       = 1,
  parameter int unsigned PATTERN_SEED = 32'hA5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  output logic [ADDR_BITS-1:0]  mem_addr,
  output logic [DATA_WIDTH-1:0] mem_din,
  output logic                  mem_wen,
  input  logic [DATA_WIDTH-1:0] mem_dout,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [ADDR_BITS+1:0]  err_count
`ifdef REG_MEM_BIST_FAILLOG_EN
  ,
  output logic [ADDR_BITS-1:0]  fail_addr,
  output logic [DATA_WIDTH-1:0] fail_data
`endif
);

  localparam logic [2:0] ST_IDLE = 3'd0;
  localparam logic [2:0] ST_WR_A = 3'd1;
  localparam logic [2:0] ST_RD_A = 3'd2;
  localparam logic [2:0] ST_WR_B = 3'd3;
  localparam logic [2:0] ST_RD_B = 3'd4;
  localparam logic [2:0] ST_FIN  = 3'd5;

  localparam int ERR_W = ADDR_BITS + 2;
  localparam logic [ADDR_BITS-1:0]  ADDR_MAX = '1;
  localparam logic [ADDR_BITS-1:0]  ADDR_ONE = 1;
  localparam logic [ERR_W-1:0]      ERR_MAX  = '1;
  localparam logic [ERR_W-1:0]      ERR_ONE  = 1;
  localparam logic [DATA_WIDTH-1:0] SEED     = DATA_WIDTH'(PATTERN_SEED);

`ifdef REG_MEM_BIST_FAILLOG_EN
  localparam int TAG_W = ADDR_BITS + DATA_WIDTH;
`else
  localparam int TAG_W = DATA_WIDTH;
`endif

  function automatic logic [DATA_WIDTH-1:0] pattern(input logic [ADDR_BITS-1:0] a, input logic inv);
    logic [DATA_WIDTH-1:0] p;
    p = DATA_WIDTH'(a) ^ SEED;
    return inv ? ~p : p;
  endfunction

  logic [2:0]            state_q, state_d;
  logic [ADDR_BITS-1:0]  mem_addr_q, addr_d;
  logic [DATA_WIDTH-1:0] mem_din_q, din_d;
  logic                  mem_wen_q, wen_d;
  logic                  rd_vld_q, rd_vld_d;
  logic [1:0]            drn_q, drn_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;
  logic                  pass_q, pass_d;
  logic [ERR_W-1:0]      err_q, err_d;
  logic                  go_next;
  logic                  mismatch;

  logic [TAG_W-1:0]      issue_tag, cmp_tag;
  logic                  cmp_vld;
  logic [DATA_WIDTH-1:0] cmp_exp;

  // Expected data is derived from the address currently on the bus; only RD_B inverts.
`ifdef REG_MEM_BIST_FAILLOG_EN
  assign issue_tag = {mem_addr_q, pattern(mem_addr_q, state_q == ST_RD_B)};
`else
  assign issue_tag = pattern(mem_addr_q, state_q == ST_RD_B);
`endif
  assign cmp_exp = cmp_tag[DATA_WIDTH-1:0];

  generate
    if (RD_LAT == 0) begin : g_lat0
      assign cmp_vld = rd_vld_q;
      assign cmp_tag = issue_tag;
    end else begin : g_latn
      logic [RD_LAT-1:0] vld_sh_q;
      logic [TAG_W-1:0]  tag_sh_q [RD_LAT];
      always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
          vld_sh_q <= '0;
          for (int i = 0; i < RD_LAT; i++) tag_sh_q[i] <= '0;
        end else begin
          vld_sh_q[0] <= rd_vld_q;
          tag_sh_q[0] <= issue_tag;
          for (int i = 1; i < RD_LAT; i++) begin
            vld_sh_q[i] <= vld_sh_q[i-1];
            tag_sh_q[i] <= tag_sh_q[i-1];
          end
        end
      end
      assign cmp_vld = vld_sh_q[RD_LAT-1];
      assign cmp_tag = tag_sh_q[RD_LAT-1];
    end
  endgenerate

  always_comb begin
    state_d  = state_q;
    addr_d   = mem_addr_q;
    din_d    = mem_din_q;
    wen_d    = 1'b0;
    rd_vld_d = 1'b0;
    drn_d    = drn_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    pass_d   = pass_q;
    err_d    = err_q;
    go_next  = 1'b0;
    mismatch = cmp_vld && (mem_dout != cmp_exp);
    if (mismatch && (err_q != ERR_MAX)) err_d = err_q + ERR_ONE;

    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d = ST_WR_A;
          addr_d  = '0;
          din_d   = pattern('0, 1'b0);
          wen_d   = 1'b1;
          busy_d  = 1'b1;
          err_d   = '0;
          pass_d  = 1'b0;
        end
      end
      ST_WR_A, ST_WR_B: begin
        if (mem_addr_q == ADDR_MAX) begin
          state_d  = (state_q == ST_WR_A) ? ST_RD_A : ST_RD_B;
          addr_d   = '0;
          rd_vld_d = 1'b1;
        end else begin
          addr_d = mem_addr_q + ADDR_ONE;
          din_d  = pattern(addr_d, state_q == ST_WR_B);
          wen_d  = 1'b1;
        end
      end
      ST_RD_A, ST_RD_B: begin
        // After the last issue, hold the phase RD_LAT cycles so in-flight reads get compared.
        if (rd_vld_q) begin
          if (mem_addr_q != ADDR_MAX) begin
            addr_d   = mem_addr_q + ADDR_ONE;
            rd_vld_d = 1'b1;
          end else if (RD_LAT == 0) begin
            go_next = 1'b1;
          end else begin
            drn_d = 2'(RD_LAT - 1);
          end
        end else if (drn_q == 2'd0) begin
          go_next = 1'b1;
        end else begin
          drn_d = drn_q - 2'd1;
        end
        if (go_next) begin
          if (state_q == ST_RD_A) begin
            state_d = ST_WR_B;
            addr_d  = '0;
            din_d   = pattern('0, 1'b1);
            wen_d   = 1'b1;
          end else begin
            state_d = ST_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
            pass_d  = (err_d == '0);
          end
        end
      end
      ST_FIN:  state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= ST_IDLE;
      mem_addr_q <= '0;
      mem_din_q  <= '0;
      mem_wen_q  <= 1'b0;
      rd_vld_q   <= 1'b0;
      drn_q      <= 2'd0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      pass_q     <= 1'b0;
      err_q      <= '0;
    end else begin
      state_q    <= state_d;
      mem_addr_q <= addr_d;
      mem_din_q  <= din_d;
      mem_wen_q  <= wen_d;
      rd_vld_q   <= rd_vld_d;
      drn_q      <= drn_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      pass_q     <= pass_d;
      err_q      <= err_d;
    end
  end

`ifdef REG_MEM_BIST_FAILLOG_EN
  logic [ADDR_BITS-1:0]  fail_addr_q;
  logic [DATA_WIDTH-1:0] fail_data_q;

  // A zero error count before this compare marks the first mismatch of the run.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if ((state_q == ST_IDLE) && start) begin
      fail_addr_q <= '0;
      fail_data_q <= '0;
    end else if (mismatch && (err_q == '0)) begin
      fail_addr_q <= cmp_tag[TAG_W-1:DATA_WIDTH];
      fail_data_q <= mem_dout;
    end
  end

  assign fail_addr = fail_addr_q;
  assign fail_data = fail_data_q;
`endif

  assign mem_addr  = mem_addr_q;
  assign mem_din   = mem_din_q;
  assign mem_wen   = mem_wen_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pass      = pass_q;
  assign err_count = err_q;

endmodule

// File: tb/tb_reg_mem_bist.sv
// tb/tb_reg_mem_bist.sv - scoreboard bench for reg_mem_bist at RD_LAT 0, 1 and 2.
module tb_reg_mem_bist;

  typedef struct {
    int   cyc;
    logic pass;
    int   err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  int   mode1 = 0;

  logic [4:0] addr0, addr1, addr2;
  logic [7:0] din0, din1, din2;
  logic       wen0, wen1, wen2;
  logic [7:0] dout0, dout1, dout2;
  logic       busy0, busy1, busy2;
  logic       done0, done1, done2;
  logic       pass0, pass1, pass2;
  logic [6:0] err0, err1, err2;
`ifdef REG_MEM_BIST_FAILLOG_EN
  logic [4:0] fa0, fa1, fa2;
  logic [7:0] fd0, fd1, fd2;
`endif

  exp_t q0[$], q1[$], q2[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  reg_mem_bist #(.RD_LAT(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .mem_addr(addr0), .mem_din(din0), .mem_wen(wen0),
    .mem_dout(dout0), .busy(busy0), .done(done0), .pass(pass0), .err_count(err0)
`ifdef REG_MEM_BIST_FAILLOG_EN
    , .fail_addr(fa0), .fail_data(fd0)
`endif
  );
  reg_mem_bist #(.RD_LAT(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .mem_addr(addr1), .mem_din(din1), .mem_wen(wen1),
    .mem_dout(dout1), .busy(busy1), .done(done1), .pass(pass1), .err_count(err1)
`ifdef REG_MEM_BIST_FAILLOG_EN
    , .fail_addr(fa1), .fail_data(fd1)
`endif
  );
  reg_mem_bist #(.RD_LAT(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .mem_addr(addr2), .mem_din(din2), .mem_wen(wen2),
    .mem_dout(dout2), .busy(busy2), .done(done2), .pass(pass2), .err_count(err2)
`ifdef REG_MEM_BIST_FAILLOG_EN
    , .fail_addr(fa2), .fail_data(fd2)
`endif
  );

  // Memory models: combinational, one-register and two-register read paths.
  logic [7:0] m0 [32];
  logic [7:0] m1 [32];
  logic [7:0] m2 [32];
  logic [7:0] d2a;

  function automatic logic [7:0] rd_fix(input logic [7:0] d, input logic [4:0] a);
    case (mode1)
      1:       return (a == 5'd7) ? (d | 8'h01) : d;
      2:       return 8'h00;
      default: return d;
    endcase
  endfunction

  assign dout0 = m0[addr0];
  always @(posedge clk) begin
    if (wen0) m0[addr0] <= din0;
    if (wen1) m1[addr1] <= din1;
    if (wen2) m2[addr2] <= din2;
    dout1 <= rd_fix(m1[addr1], addr1);
    d2a   <= m2[addr2];
    dout2 <= d2a;
  end

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s got=%0h want=%0h", nm, got, want);
    end
  endtask

  // Write-trace logger for dut1.
  int         wr_cnt = 0;
  int         wr_order_bad = 0;
  logic [7:0] wr_a [32];
  logic [7:0] wr_b [32];
  always @(negedge clk) begin
    if (wen1) begin
      if (wr_cnt < 32) wr_a[addr1] <= din1;
      else if (wr_cnt < 64) wr_b[addr1] <= din1;
      if (addr1 != 5'(wr_cnt)) wr_order_bad <= wr_order_bad + 1;
      wr_cnt <= wr_cnt + 1;
    end
  end

  // Monitors: pop expected result on every done pulse.
  always @(negedge clk) begin : mon0
    exp_t e;
    if (!rst && done0) begin
      if (q0.size() == 0) chk("done0_unexpected", done0, 0);
      else begin
        e = q0.pop_front();
        chk("done0_cycle", cyc, e.cyc);
        chk("done0_pass", pass0, e.pass);
        chk("done0_err", err0, e.err);
        chk("done0_busy", busy0, 0);
      end
    end
  end
  always @(negedge clk) begin : mon1
    exp_t e;
    if (!rst && done1) begin
      if (q1.size() == 0) chk("done1_unexpected", done1, 0);
      else begin
        e = q1.pop_front();
        chk("done1_cycle", cyc, e.cyc);
        chk("done1_pass", pass1, e.pass);
        chk("done1_err", err1, e.err);
        chk("done1_busy", busy1, 0);
      end
    end
  end
  always @(negedge clk) begin : mon2
    exp_t e;
    if (!rst && done2) begin
      if (q2.size() == 0) chk("done2_unexpected", done2, 0);
      else begin
        e = q2.pop_front();
        chk("done2_cycle", cyc, e.cyc);
        chk("done2_pass", pass2, e.pass);
        chk("done2_err", err2, e.err);
        chk("done2_busy", busy2, 0);
      end
    end
  end

  task automatic set_start(input int k, input logic v);
    case (k)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  function automatic logic get_busy(input int k);
    case (k)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  function automatic int qsize(input int k);
    case (k)
      0:       return q0.size();
      1:       return q1.size();
      default: return q2.size();
    endcase
  endfunction

  task automatic launch(input int k, input bit push, input logic ep, input int ee, input int lat);
    exp_t e;
    @(negedge clk);
    set_start(k, 1'b1);
    @(negedge clk);
    set_start(k, 1'b0);
    chk($sformatf("busy_rise%0d", k), get_busy(k), 1);
    if (push) begin
      e.cyc  = cyc + lat;
      e.pass = ep;
      e.err  = ee;
      case (k)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic wait_empty(input int k);
    int n;
    n = 0;
    while (qsize(k) != 0 && n < 400) begin
      @(negedge clk);
      n++;
    end
    if (qsize(k) != 0) chk($sformatf("done%0d_timeout", k), qsize(k), 0);
  endtask

  task automatic chk_reset_vals();
    chk("rst_addr", addr1, 0);
    chk("rst_din", din1, 0);
    chk("rst_wen", wen1, 0);
    chk("rst_busy", busy1, 0);
    chk("rst_done", done1, 0);
    chk("rst_pass", pass1, 0);
    chk("rst_err", err1, 0);
  endtask

  initial begin : watchdog
    #500000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    chk_reset_vals();
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // Clean memory, default latency, with write trace.
    mode1 = 0;
    launch(1, 1'b1, 1'b1, 0, 130);
    wait_empty(1);
    chk("wr_count", wr_cnt, 64);
    chk("wr_order", wr_order_bad, 0);
    chk("wr_a0", wr_a[0], 8'hA5);
    chk("wr_a31", wr_a[31], 8'hBA);
    chk("wr_b0", wr_b[0], 8'h5A);
    chk("wr_b31", wr_b[31], 8'h45);

    // Stuck-at-1 on bit 0 of address 7.
    mode1 = 1;
    launch(1, 1'b1, 1'b0, 1, 130);
    wait_empty(1);
`ifdef REG_MEM_BIST_FAILLOG_EN
    chk("fail_addr", fa1, 7);
    chk("fail_data", fd1, 8'hA3);
`endif

    // All-zero read data.
    mode1 = 2;
    launch(1, 1'b1, 1'b0, 64, 130);
    wait_empty(1);
    repeat (5) @(negedge clk);
    chk("hold_err", err1, 64);
    chk("hold_pass", pass1, 0);

    // Reset 40 cycles into a run: immediate clear and no done.
    mode1 = 0;
    launch(1, 1'b0, 1'b0, 0, 0);
    repeat (39) @(negedge clk);
    #1 rst = 1'b1;
    #1 chk_reset_vals();
    @(negedge clk);
    rst = 1'b0;
    repeat (150) @(negedge clk);
    launch(1, 1'b1, 1'b1, 0, 130);
    wait_empty(1);

    // RD_LAT 0 and 2, with an ignored start pulse mid-run.
    launch(0, 1'b1, 1'b1, 0, 128);
    repeat (50) @(negedge clk);
    start0 = 1'b1;
    @(negedge clk);
    start0 = 1'b0;
    wait_empty(0);

    launch(2, 1'b1, 1'b1, 0, 132);
    repeat (60) @(negedge clk);
    start2 = 1'b1;
    @(negedge clk);
    start2 = 1'b0;
    wait_empty(2);

    repeat (140) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
